// File: rtl/sonar_sequencer.sv
// Round-robin sonar sequencer: fires each enabled sensor in turn, ships its result, then idles for a guard gap.
// Latency: first med_start 2 clocks after ligar is sampled; all outputs registered. Optional timeout via SONAR_SEQ_TIMEOUT_EN.
// Backpressure: waits on med_fim[sel] from the sensor and tx_pronto from the transmitter before advancing.
module sonar_sequencer #(
    parameter int TIMEOUT_CICLOS = 1500000,
    parameter int GUARDA_CICLOS  = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ligar,
    input  logic       continuo,
    input  logic [2:0] mask,
    input  logic [2:0] med_fim,
    input  logic       tx_pronto,
    output logic [2:0] med_start,
    output logic       tx_start,
    output logic [1:0] sel,
    output logic [2:0] timeout,
    output logic       ocupado,
    output logic       pronto,
    output logic [3:0] db_estado
);

    localparam logic [3:0] S_IDLE       = 4'd0;
    localparam logic [3:0] S_PREPARA    = 4'd1;
    localparam logic [3:0] S_INICIA     = 4'd2;
    localparam logic [3:0] S_ESPERA_MED = 4'd3;
    localparam logic [3:0] S_TRANSMITE  = 4'd4;
    localparam logic [3:0] S_ESPERA_TX  = 4'd5;
    localparam logic [3:0] S_GUARDA     = 4'd6;
    localparam logic [3:0] S_FIM        = 4'd7;

    // A zero-length wait still costs one clock in its state.
    localparam int T_EFF   = (TIMEOUT_CICLOS < 1) ? 1 : TIMEOUT_CICLOS;
    localparam int G_EFF   = (GUARDA_CICLOS < 1) ? 1 : GUARDA_CICLOS;
    localparam int CNT_MAX = (T_EFF > G_EFF) ? T_EFF : G_EFF;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] G_LAST = CW'(G_EFF - 1);
`ifdef SONAR_SEQ_TIMEOUT_EN
    localparam logic [CW-1:0] T_LAST = CW'(T_EFF - 1);
`endif

    logic [3:0]    state_q, state_d;
    logic [1:0]    sel_q, sel_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [2:0]    visited_q, visited_d;
    logic [2:0]    mask_q, mask_d;
    logic [2:0]    timeout_q, timeout_d;
    logic [2:0]    med_start_q, med_start_d;
    logic          tx_start_q, tx_start_d;
    logic          pronto_q, pronto_d;
    logic          ocupado_q, ocupado_d;
    logic [2:0]    sel_oh;
    logic [2:0]    pending;

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        cnt_d     = cnt_q;
        visited_d = visited_q;
        mask_d    = mask_q;
        timeout_d = timeout_q;
        sel_oh    = 3'b001 << sel_q;
        pending   = mask_q & ~visited_q;
        cnt_inc   = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                if (ligar) begin
                    mask_d    = mask;
                    visited_d = 3'b000;
                    timeout_d = 3'b000;
                    state_d   = S_PREPARA;
                end
            end
            S_PREPARA: begin
                if (pending[0]) begin
                    sel_d   = 2'd0;
                    state_d = S_INICIA;
                end else if (pending[1]) begin
                    sel_d   = 2'd1;
                    state_d = S_INICIA;
                end else if (pending[2]) begin
                    sel_d   = 2'd2;
                    state_d = S_INICIA;
                end else begin
                    state_d = S_FIM;
                end
            end
            S_INICIA: begin
                cnt_d   = '0;
                state_d = S_ESPERA_MED;
            end
            S_ESPERA_MED: begin
                // A done pulse on the expiry clock takes priority over the timeout.
                if (|(med_fim & sel_oh)) begin
                    state_d = S_TRANSMITE;
`ifdef SONAR_SEQ_TIMEOUT_EN
                end else if (cnt_q >= T_LAST) begin
                    timeout_d = timeout_q | sel_oh;
                    cnt_d     = '0;
                    state_d   = S_GUARDA;
`endif
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_TRANSMITE: begin
                state_d = S_ESPERA_TX;
            end
            S_ESPERA_TX: begin
                if (tx_pronto) begin
                    cnt_d   = '0;
                    state_d = S_GUARDA;
                end
            end
            S_GUARDA: begin
                if (cnt_q >= G_LAST) begin
                    visited_d = visited_q | sel_oh;
                    state_d   = S_PREPARA;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_FIM: begin
                if (continuo) begin
                    mask_d    = mask;
                    visited_d = 3'b000;
                    timeout_d = 3'b000;
                    state_d   = S_PREPARA;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Pulses are decoded from the next state so they line up with the state they belong to.
        med_start_d = (state_d == S_INICIA) ? (3'b001 << sel_d) : 3'b000;
        tx_start_d  = (state_d == S_TRANSMITE);
        pronto_d    = (state_d == S_FIM);
        ocupado_d   = (state_d != S_IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            sel_q       <= 2'd0;
            cnt_q       <= '0;
            visited_q   <= 3'b000;
            mask_q      <= 3'b000;
            timeout_q   <= 3'b000;
            med_start_q <= 3'b000;
            tx_start_q  <= 1'b0;
            pronto_q    <= 1'b0;
            ocupado_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
            visited_q   <= visited_d;
            mask_q      <= mask_d;
            timeout_q   <= timeout_d;
            med_start_q <= med_start_d;
            tx_start_q  <= tx_start_d;
            pronto_q    <= pronto_d;
            ocupado_q   <= ocupado_d;
        end
    end

    assign med_start = med_start_q;
    assign tx_start  = tx_start_q;
    assign sel       = sel_q;
    assign timeout   = timeout_q;
    assign ocupado   = ocupado_q;
    assign pronto    = pronto_q;
    assign db_estado = state_q;

endmodule
